// File: rtl/alu_pkg.sv
// Shared definitions for the integer ALU cluster: optype encodings, widths
// and the per-ALU issue payload.
package alu_pkg;

  localparam int NUM_ALU = 3;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;
  localparam int OPT_W   = 4;

  localparam logic [OPT_W-1:0] OP_ADD = 4'd1;
  localparam logic [OPT_W-1:0] OP_SUB = 4'd2;
  localparam logic [OPT_W-1:0] OP_AND = 4'd3;
  localparam logic [OPT_W-1:0] OP_OR  = 4'd4;
  localparam logic [OPT_W-1:0] OP_XOR = 4'd5;
  localparam logic [OPT_W-1:0] OP_SLL = 4'd6;
  localparam logic [OPT_W-1:0] OP_SRL = 4'd7;
  localparam logic [OPT_W-1:0] OP_LW  = 4'd8;
  localparam logic [OPT_W-1:0] OP_SW  = 4'd9;

  typedef struct packed {
    logic [OPT_W-1:0]  optype;
    logic [DATA_W-1:0] sr1;
    logic [DATA_W-1:0] sr2;
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  dr;
  } issue_t;

  // Lowest-numbered set bit of a free-ALU mask (caller guarantees non-zero).
  function automatic logic [1:0] lowest_free(input logic [NUM_ALU-1:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

endpackage

// File: rtl/alu_issue_scheduler_picker.sv
// rr_multi_picker: combinational multi-winner picker. Scans the valid vector
// starting at 'start' (wrapping) and hands each valid entry, in scan order,
// to the lowest still-free ALU until entries or free ALUs run out.
module rr_multi_picker
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 8,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]                valid,
  input  logic [IDX_W-1:0]                  start,
  input  logic [NUM_ALU-1:0]                free_mask,
  output logic [NUM_ALU-1:0][NUM_REQ-1:0]   pick_oh,
  output logic [NUM_ALU-1:0]                pick_vld,
  output logic [NUM_ALU-1:0][IDX_W-1:0]     pick_idx,
  output logic [NUM_ALU-1:0][1:0]           pick_alu
);

  logic [NUM_ALU-1:0] free_left;
  logic [1:0]         n_pick;
  logic [IDX_W-1:0]   idx;
  logic [1:0]         alu_k;

  // Walk entries in priority order; each hit consumes the lowest free ALU.
  always_comb begin
    pick_oh   = '0;
    pick_vld  = '0;
    pick_idx  = '0;
    pick_alu  = '0;
    free_left = free_mask;
    n_pick    = 2'd0;
    idx       = '0;
    alu_k     = 2'd0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = start + IDX_W'(off);
      if (valid[idx] && (free_left != '0)) begin
        alu_k            = lowest_free(free_left);
        pick_vld[n_pick] = 1'b1;
        pick_idx[n_pick] = idx;
        pick_oh[n_pick]  = NUM_REQ'(1) << idx;
        pick_alu[n_pick] = alu_k;
        free_left[alu_k] = 1'b0;
        n_pick           = n_pick + 2'd1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// alu_issue_scheduler: issues up to three ready RS entries per cycle into the
// per-ALU issue registers. Build option ALU_ISSUE_RR_EN selects a round-robin
// scan start (rr_ptr); without it the scan is fixed priority from entry 0.
module alu_issue_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [OPT_W*NUM_REQ-1:0]    req_optype,
  input  logic [DATA_W*NUM_REQ-1:0]   req_sr1,
  input  logic [DATA_W*NUM_REQ-1:0]   req_sr2,
  input  logic [DATA_W*NUM_REQ-1:0]   req_imm,
  input  logic [TAG_W*NUM_REQ-1:0]    req_dr,
  output logic [NUM_REQ-1:0]          req_grant,
  input  logic [NUM_ALU-1:0]          alu_stall,
  output logic [NUM_ALU-1:0]          alu_number,
  output logic [OPT_W*NUM_ALU-1:0]    alu_optype,
  output logic [DATA_W*NUM_ALU-1:0]   alu_sr1,
  output logic [DATA_W*NUM_ALU-1:0]   alu_sr2,
  output logic [DATA_W*NUM_ALU-1:0]   alu_imm,
  output logic [TAG_W*NUM_ALU-1:0]    alu_dr,
  output logic [31:0]                 issue_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_ALU-1:0]              alu_free;
  logic [NUM_ALU-1:0]              pick_free;
  logic [IDX_W-1:0]                scan_start;
  logic [NUM_ALU-1:0][NUM_REQ-1:0] pick_oh;
  logic [NUM_ALU-1:0]              pick_vld;
  logic [NUM_ALU-1:0][IDX_W-1:0]   pick_idx;
  logic [NUM_ALU-1:0][1:0]         pick_alu;
  logic [NUM_ALU-1:0]              alu_load;
  logic [NUM_ALU-1:0][IDX_W-1:0]   alu_src;
  logic [1:0]                      grant_cnt;
  issue_t [NUM_ALU-1:0]            next_pl;
  issue_t [NUM_ALU-1:0]            alu_pl;

  // A stalled ALU that still holds an op is the only non-free case.
  assign alu_free  = ~alu_stall | ~alu_number;
  // Flush and reset suppress every grant by offering no free ALU.
  assign pick_free = (flush || !rstn) ? '0 : alu_free;

`ifdef ALU_ISSUE_RR_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] last_idx;

  // Last winner in scan order decides where the next scan starts.
  always_comb begin
    if (pick_vld[2])      last_idx = pick_idx[2];
    else if (pick_vld[1]) last_idx = pick_idx[1];
    else                  last_idx = pick_idx[0];
  end

  // Round-robin pointer: one past the last grant, cleared by flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            rr_ptr <= '0;
    else if (flush)       rr_ptr <= '0;
    else if (pick_vld[0]) rr_ptr <= last_idx + IDX_W'(1);
  end

  assign scan_start = rr_ptr;
`else
  assign scan_start = '0;
`endif

  rr_multi_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid     (req_valid),
    .start     (scan_start),
    .free_mask (pick_free),
    .pick_oh   (pick_oh),
    .pick_vld  (pick_vld),
    .pick_idx  (pick_idx),
    .pick_alu  (pick_alu)
  );

  // Map picks back to per-ALU load enables and source entries; count grants.
  always_comb begin
    req_grant = '0;
    alu_load  = '0;
    alu_src   = '0;
    for (int p = 0; p < NUM_ALU; p++) begin
      req_grant = req_grant | pick_oh[p];
      if (pick_vld[p]) begin
        alu_load[pick_alu[p]] = 1'b1;
        alu_src[pick_alu[p]]  = pick_idx[p];
      end
    end
    grant_cnt = {1'b0, pick_vld[0]} + {1'b0, pick_vld[1]} + {1'b0, pick_vld[2]};
  end

  // Select each ALU's incoming payload from its assigned entry.
  always_comb begin
    next_pl = '0;
    for (int k = 0; k < NUM_ALU; k++) begin
      next_pl[k].optype = req_optype[OPT_W*alu_src[k] +: OPT_W];
      next_pl[k].sr1    = req_sr1[DATA_W*alu_src[k] +: DATA_W];
      next_pl[k].sr2    = req_sr2[DATA_W*alu_src[k] +: DATA_W];
      next_pl[k].imm    = req_imm[DATA_W*alu_src[k] +: DATA_W];
      next_pl[k].dr     = req_dr[TAG_W*alu_src[k] +: TAG_W];
    end
  end

  // Issue registers: load on assign, clear when free, hold when stalled; flush drops all.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alu_number <= '0;
      alu_pl     <= '0;
      issue_cnt  <= '0;
    end else begin
      issue_cnt <= issue_cnt + 32'(grant_cnt);
      for (int k = 0; k < NUM_ALU; k++) begin
        if (flush) begin
          alu_number[k] <= 1'b0;
        end else if (alu_load[k]) begin
          alu_number[k] <= 1'b1;
          alu_pl[k]     <= next_pl[k];
        end else if (alu_free[k]) begin
          alu_number[k] <= 1'b0;
        end
      end
    end
  end

  // Flatten the issue registers onto the ALU-facing buses.
  always_comb begin
    alu_optype = '0;
    alu_sr1    = '0;
    alu_sr2    = '0;
    alu_imm    = '0;
    alu_dr     = '0;
    for (int k = 0; k < NUM_ALU; k++) begin
      alu_optype[OPT_W*k +: OPT_W]   = alu_pl[k].optype;
      alu_sr1[DATA_W*k +: DATA_W]    = alu_pl[k].sr1;
      alu_sr2[DATA_W*k +: DATA_W]    = alu_pl[k].sr2;
      alu_imm[DATA_W*k +: DATA_W]    = alu_pl[k].imm;
      alu_dr[TAG_W*k +: TAG_W]       = alu_pl[k].dr;
    end
  end

endmodule

// File: doc/alu_issue_scheduler.md
# alu_issue_scheduler

Issue-stage scheduler for the integer ALU cluster. It arbitrates among `NUM_REQ` ready reservation-station entries and assigns up to three of them per cycle to ALU0..ALU2. It registers each winner's operands, optype and destination tag into per-ALU issue registers that drive the ALUs' `alu_number`/`optype`/`data_in_*`/`dr_in` inputs. It sits between the reservation station and the ALUs and is the only driver of `alu_number`.

## Interface
- `NUM_REQ`, 8: requester (RS entry) count, power of two, 4..16
- `NUM_ALU`, 3: ALU count; fixed at 3, matches `alu_number` width
- `clk`  in  1  clock, rising edge
- `rstn`  in  1  asynchronous active-low reset
- `flush`  in  1  synchronous pipeline flush (mispredict)
- `req_valid`  in  NUM_REQ  entry i ready to issue
- `req_optype`  in  4*NUM_REQ  entry i optype, slice [4i+3:4i]
- `req_sr1`, `req_sr2`, `req_imm`  in  32*NUM_REQ  entry i operands
- `req_dr`  in  6*NUM_REQ  entry i physical destination tag
- `req_grant`  out  NUM_REQ  combinational one-cycle grant to entry i
- `alu_stall`  in  NUM_ALU  ALU k result not accepted; hold its issue register
- `alu_number`  out  3  bit k = ALU k holds a valid op (registered)
- `alu_optype`  out  4*NUM_ALU  per-ALU optype (registered)
- `alu_sr1`, `alu_sr2`, `alu_imm`  out  32*NUM_ALU  per-ALU operands (registered)
- `alu_dr`  out  6*NUM_ALU  per-ALU destination tag (registered)
- `issue_cnt`  out  32  total ops issued since reset, wraps

## Operation
- Free ALU k: `alu_stall[k]`=0 or `alu_number[k]`=0. A stalled ALU holding an op is never assigned.
- Selection: scan requesters in priority order starting at `rr_ptr`. The first valid entry goes to the lowest-numbered free ALU, the next to the next free ALU, and so on, until the free ALUs or the valid entries run out. At most one grant per entry.
- `req_grant[i]`=1 in the same cycle entry i is selected. The RS must invalidate or replace the entry on the following edge.
- Optype is passed through unchecked. Values 1..9 are valid. Any other value is still issued; the ALU ignores it.
- At the clock edge:
  - An assigned ALU loads the payload and sets `alu_number[k]`=1.
  - A free, unassigned ALU clears `alu_number[k]`. Payload registers are don't-care.
  - A stalled ALU with a valid op holds all of its registers.
- `rr_ptr` becomes (index of last granted entry + 1) mod `NUM_REQ`. It is unchanged if nothing was granted.
- `issue_cnt` adds the number of grants (0..3) each cycle.
- `flush`=1:
  - All `req_grant`=0.
  - Next edge: `alu_number`=0, including stalled ALUs, and `rr_ptr`=0.
  - `issue_cnt` is unchanged.

## Timing
- Reset values (async, immediate): `alu_number`=0, all payload outputs 0, `rr_ptr`=0, `issue_cnt`=0. `req_grant` is 0 while `rstn`=0.
- Latency: entry valid in cycle N leads to grant in cycle N and ALU inputs valid in cycle N+1. The ALU result is combinational in N+1.
- `req_grant` depends combinationally on `req_valid`, `alu_stall`, `alu_number`, `rr_ptr`, `flush`. No path from payload inputs to grant.
- Simultaneous stall and flush: flush wins and the op is dropped.
- Reset deasserted mid-stream: the first grant is possible in the first cycle after `rstn` rises.
- `rr_ptr` wraps from `NUM_REQ-1` to 0.
- `issue_cnt` wraps from 2^32-1 to 0.

## Configuration
- `ALU_ISSUE_RR_EN` defined: round-robin scan from `rr_ptr` as above.
- Undefined: fixed priority. Scan always starts at entry 0, `rr_ptr` logic is removed and lower index always wins.
- All other behaviour is identical in both builds.

## Structure
- Shared package `alu_pkg`:
  - optype localparams `OP_ADD`=1 … `OP_SW`=9
  - `NUM_ALU`=3
  - `TAG_W`=6
  - `DATA_W`=32
  - issue-payload struct: optype, sr1, sr2, imm, dr
- One sub-module, `rr_multi_picker`: given valid vector, start pointer and free-ALU mask, returns up to three one-hot picks plus the assigned ALU per pick. Purely combinational.
- The top holds the issue registers, `rr_ptr`, counter and flush logic.

## Test plan
- Reset: assert `rstn`=0 mid-traffic → `alu_number`=0, `issue_cnt`=0 immediately. First grant in the first cycle after release.
- Single request: `req_valid`=8'b0000_0100, optype 1, sr1=5, sr2=7, dr=12 → `req_grant`=8'b0000_0100. Next cycle `alu_number`=3'b001, ALU0 sr1=5, sr2=7, dr=12.
- Oversubscription with RR: all 8 valid, `rr_ptr`=0.
  - Cycle 1: grants entries 0,1,2 to ALU0,1,2 and `rr_ptr`→3.
  - Cycle 2: grants 3,4,5.
  - Cycle 3: grants 6,7,0, wrapping to `rr_ptr`=1.
- Stall: `alu_stall`=3'b010 with ALU1 valid and 4 requests pending → ALU1 registers hold. Entries go to ALU0 and ALU2 only, 2 grants, `issue_cnt`+=2.
- Flush during stall: `flush`=1, `alu_stall`=3'b111 → no grants. Next cycle `alu_number`=0, `rr_ptr`=0.
- Fixed-priority build (macro undefined): entries 5 and 6 valid for 3 cycles with the RS re-asserting → entry 5 always wins ALU0, entry 6 ALU1.
